ps2_key_event_decoder: RTL and testbench
========================================

PS2_KEY_EVENT_DECODER -- requirements
Module: ps2_key_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO depth; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rx_done_tick, input, 1, one-cycle pulse from the PS/2 receiver marking a complete frame.
REQ-005 SHALL have port b_reg, input, 11, received frame: [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-006 SHALL have port rx_en, output, 1, receive enable back to the receiver; equals ~fifo_full.
REQ-007 SHALL have port rd_en, input, 1, consumer pop request.
REQ-008 SHALL have port ev_valid, output, 1, FIFO non-empty; head event valid.
REQ-009 SHALL have port ev_code, output, 8, head event scan code.
REQ-010 SHALL have port ev_ext, output, 1, head event carried the 0xE0 prefix.
REQ-011 SHALL have port ev_break, output, 1, head event is a key release (0xF0 prefix).
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a rejected frame or illegal prefix sequence.
REQ-013 SHALL have port overflow, output, 1, one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-014 SHALL sample b_reg only in cycles where rx_done_tick=1.
REQ-015 SHALL accept a frame only if b_reg[0]=0, b_reg[10]=1 and XOR of b_reg[9:1]=1 (odd parity); otherwise it SHALL pulse frame_err, force state to S_IDLE and push nothing.
REQ-016 SHALL implement prefix FSM states S_IDLE, S_E0, S_F0, S_E0F0; it SHALL transition only on accepted frames.
REQ-017 In S_IDLE: 0xE0 -> S_E0; 0xF0 -> S_F0; any other code -> push {ext=0,brk=0,code}, stay.
REQ-018 In S_E0: 0xF0 -> S_E0F0; 0xE0 -> stay S_E0; other -> push {1,0,code}, go S_IDLE.
REQ-019 In S_F0: 0xE0 or 0xF0 -> frame_err pulse, S_IDLE, no push; other -> push {0,1,code}, go S_IDLE.
REQ-020 In S_E0F0: 0xE0 or 0xF0 -> frame_err pulse, S_IDLE, no push; other -> push {1,1,code}, go S_IDLE.
REQ-021 Pushed event SHALL be visible on ev_* with ev_valid=1 in the cycle after rx_done_tick when the FIFO was empty (1-cycle latency, first-word-fall-through).
REQ-022 rd_en with ev_valid=1 SHALL pop the head; rd_en with ev_valid=0 SHALL be ignored.
REQ-023 Push while full without simultaneous pop SHALL drop the event and pulse overflow; FSM still returns to S_IDLE.
REQ-024 Simultaneous push and pop when full SHALL both succeed with no overflow; when empty, push succeeds and pop is ignored.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-026 frame_err and overflow SHALL be registered, one cycle wide, asserted in the cycle after the causing rx_done_tick.

Reset
REQ-027 On reset: state=S_IDLE, FIFO empty, ev_valid=0, ev_code=0x00, ev_ext=0, ev_break=0, frame_err=0, overflow=0, rx_en=1.
REQ-028 Reset asserted mid-sequence (e.g. after 0xE0) SHALL discard the pending prefix and all queued events.

Structure
REQ-029 Shared package SHALL hold SC_EXT=8'hE0, SC_BRK=8'hF0, state encodings, and event width constant EV_W=10.
REQ-030 FIFO SHALL be a sub-module named ps2_event_fifo (EV_W data, FIFO_DEPTH, push/pop/full/empty).

Verification
REQ-031 Valid frame 0x1C -> one event {code=0x1C, ext=0, brk=0}, ev_valid=1 one cycle after the tick.
REQ-032 Frames E0, F0, 0x75 -> exactly one event {0x75, ext=1, brk=1}; no events for the prefixes.
REQ-033 Frame 0x1C with parity bit flipped -> frame_err pulse, no event; then F0, 0x1C -> {0x1C, 0, 1}.
REQ-034 Five codes with no reads (FIFO_DEPTH=4) -> four events queued, overflow pulse on the fifth, rx_en=0 while full; pops return them in order.
REQ-035 Full FIFO, rd_en coincident with a new tick -> no overflow, occupancy stays 4, new code at tail.
REQ-036 Frames F0, F0 -> frame_err on the second; reset after E0, then 0x1C -> {0x1C, ext=0, brk=0}.

Source files
------------

// File: rtl/ps2_key_event_decoder_pkg.sv
// rtl/ps2_key_event_decoder_pkg.sv - shared constants, state encoding and frame check for the PS/2 key event decoder
package ps2_key_event_decoder_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Event word layout: {ext, brk, code[7:0]}
  localparam int EV_W = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } state_t;

  // Start bit low, stop bit high, odd parity over data plus parity bit
  function automatic logic frame_ok(input logic [10:0] frame);
    return !frame[0] && frame[10] && (^frame[9:1]);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word-fall-through event FIFO with occupancy counter
module ps2_event_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if the head leaves the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head is forced to zero while empty so the event outputs read as idle
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - turns PS/2 frames into make/break/extended key events queued in a FIFO
module ps2_key_event_decoder
  import ps2_key_event_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [10:0] b_reg,
  output logic        rx_en,
  input  logic        rd_en,
  output logic        ev_valid,
  output logic [7:0]  ev_code,
  output logic        ev_ext,
  output logic        ev_break,
  output logic        frame_err,
  output logic        overflow
);

  state_t          state_q, state_d;
  logic            push_d;
  logic            err_d;
  logic            ovf_d;
  logic [EV_W-1:0] ev_d;
  logic [EV_W-1:0] head;
  logic [7:0]      code;
  logic            full;
  logic            empty;
  logic            frame_err_q;
  logic            overflow_q;

  assign code = b_reg[8:1];

  // Prefix decode: next state, event to push and error flag for the current tick
  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    err_d   = 1'b0;
    ev_d    = '0;
    if (rx_done_tick) begin
      if (!frame_ok(b_reg)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (code == SC_EXT)      state_d = S_E0;
            else if (code == SC_BRK) state_d = S_F0;
            else begin
              push_d = 1'b1;
              ev_d   = {1'b0, 1'b0, code};
            end
          end
          S_E0: begin
            if (code == SC_BRK)      state_d = S_E0F0;
            else if (code == SC_EXT) state_d = S_E0;
            else begin
              push_d  = 1'b1;
              ev_d    = {1'b1, 1'b0, code};
              state_d = S_IDLE;
            end
          end
          S_F0: begin
            state_d = S_IDLE;
            if (code == SC_EXT || code == SC_BRK) err_d = 1'b1;
            else begin
              push_d = 1'b1;
              ev_d   = {1'b0, 1'b1, code};
            end
          end
          S_E0F0: begin
            state_d = S_IDLE;
            if (code == SC_EXT || code == SC_BRK) err_d = 1'b1;
            else begin
              push_d = 1'b1;
              ev_d   = {1'b1, 1'b1, code};
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // A full FIFO is never empty, so any rd_en frees a slot for the incoming event
  assign ovf_d = push_d && full && !rd_en;

  // Prefix state and registered one-cycle status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= err_d;
      overflow_q  <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_d),
    .pop_i   (rd_en),
    .data_i  (ev_d),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rx_en     = !full;
  assign ev_valid  = !empty;
  assign ev_ext    = head[9];
  assign ev_break  = head[8];
  assign ev_code   = head[7:0];
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb/tb_ps2_key_event_decoder.sv - directed self-checking bench for the PS/2 key event decoder
module tb_ps2_key_event_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done_tick = 1'b0;
  logic [10:0] b_reg = '0;
  logic        rx_en;
  logic        rd_en = 1'b0;
  logic        ev_valid;
  logic [7:0]  ev_code;
  logic        ev_ext;
  logic        ev_break;
  logic        frame_err;
  logic        overflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ps2_key_event_decoder #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .b_reg        (b_reg),
    .rx_en        (rx_en),
    .rd_en        (rd_en),
    .ev_valid     (ev_valid),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic flip);
    logic par;
    par = ~(^code) ^ flip;
    return {1'b1, par, code, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // {valid, ext, brk, code}
  task automatic chk_ev(input string tag, input logic v, input logic e, input logic b, input logic [7:0] c);
    chk(tag, {21'd0, ev_valid, ev_ext, ev_break, ev_code}, {21'd0, v, e, b, c});
  endtask

  // Called at a negedge; returns at the following negedge with tick deasserted
  task automatic send(input logic [7:0] code, input logic flip, input logic rd);
    b_reg        = mk_frame(code, flip);
    rx_done_tick = 1'b1;
    rd_en        = rd;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rd_en        = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk_ev("reset_ev", 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_rx_en", 32'(rx_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // plain make code
    send(8'h1C, 1'b0, 1'b0);
    chk_ev("make_1c", 1'b1, 1'b0, 1'b0, 8'h1C);
    chk("make_1c_ferr", 32'(frame_err), 32'd0);
    pop();
    chk("make_1c_popped", 32'(ev_valid), 32'd0);

    // extended break
    send(8'hE0, 1'b0, 1'b0);
    chk("e0_no_event", 32'(ev_valid), 32'd0);
    send(8'hF0, 1'b0, 1'b0);
    chk("e0f0_no_event", 32'(ev_valid), 32'd0);
    send(8'h75, 1'b0, 1'b0);
    chk_ev("ext_break_75", 1'b1, 1'b1, 1'b1, 8'h75);
    pop();
    chk("ext_break_single", 32'(ev_valid), 32'd0);

    // repeated E0 stays extended
    send(8'hE0, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0);
    send(8'h75, 1'b0, 1'b0);
    chk_ev("ext_make_75", 1'b1, 1'b1, 1'b0, 8'h75);
    pop();

    // parity error, then a good break sequence
    send(8'h1C, 1'b1, 1'b0);
    chk("parity_ferr", 32'(frame_err), 32'd1);
    chk("parity_no_event", 32'(ev_valid), 32'd0);
    idle();
    chk("parity_ferr_pulse", 32'(frame_err), 32'd0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);
    chk_ev("break_1c", 1'b1, 1'b0, 1'b1, 8'h1C);
    pop();

    // bad frame discards pending E0 prefix
    send(8'hE0, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    chk("e0_bad_ferr", 32'(frame_err), 32'd1);
    send(8'h1C, 1'b0, 1'b0);
    chk_ev("after_bad_idle", 1'b1, 1'b0, 1'b0, 8'h1C);
    pop();

    // overflow on fifth code
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    chk("three_rx_en", 32'(rx_en), 32'd1);
    send(8'h44, 1'b0, 1'b0);
    chk("full_rx_en", 32'(rx_en), 32'd0);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    send(8'h55, 1'b0, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_rx_en", 32'(rx_en), 32'd0);
    idle();
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    chk_ev("drain_11", 1'b1, 1'b0, 1'b0, 8'h11);
    pop();
    chk("drain_rx_en", 32'(rx_en), 32'd1);
    chk_ev("drain_22", 1'b1, 1'b0, 1'b0, 8'h22);
    pop();
    chk_ev("drain_33", 1'b1, 1'b0, 1'b0, 8'h33);
    pop();
    chk_ev("drain_44", 1'b1, 1'b0, 1'b0, 8'h44);
    pop();
    chk_ev("drain_empty", 1'b0, 1'b0, 1'b0, 8'h00);

    // push and pop together while full
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    send(8'hA3, 1'b0, 1'b0);
    send(8'hA4, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 1'b1);
    chk("full_pp_no_ovf", 32'(overflow), 32'd0);
    chk("full_pp_rx_en", 32'(rx_en), 32'd0);
    chk_ev("full_pp_head", 1'b1, 1'b0, 1'b0, 8'hA2);
    pop();
    chk_ev("full_pp_a3", 1'b1, 1'b0, 1'b0, 8'hA3);
    pop();
    chk_ev("full_pp_a4", 1'b1, 1'b0, 1'b0, 8'hA4);
    pop();
    chk_ev("full_pp_tail", 1'b1, 1'b0, 1'b0, 8'h5A);
    pop();
    chk("full_pp_empty", 32'(ev_valid), 32'd0);

    // push and pop together while empty
    send(8'h2B, 1'b0, 1'b1);
    chk_ev("empty_pp", 1'b1, 1'b0, 1'b0, 8'h2B);
    pop();

    // illegal F0 F0
    send(8'hF0, 1'b0, 1'b0);
    chk("f0_ok", 32'(frame_err), 32'd0);
    send(8'hF0, 1'b0, 1'b0);
    chk("f0f0_ferr", 32'(frame_err), 32'd1);
    chk("f0f0_no_event", 32'(ev_valid), 32'd0);
    send(8'h1C, 1'b0, 1'b0);
    chk_ev("f0f0_then_make", 1'b1, 1'b0, 1'b0, 8'h1C);
    pop();

    // illegal E0 F0 E0
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0);
    chk("e0f0e0_ferr", 32'(frame_err), 32'd1);
    chk("e0f0e0_no_event", 32'(ev_valid), 32'd0);

    // reset mid-sequence discards queued events and prefix
    send(8'h11, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midreset_empty", 32'(ev_valid), 32'd0);
    chk("midreset_rx_en", 32'(rx_en), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    idle();
    send(8'h1C, 1'b0, 1'b0);
    chk_ev("midreset_make", 1'b1, 1'b0, 1'b0, 8'h1C);
    pop();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
